// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy / pattern fill master for the single-port data memory
//
// Purpose: copies a run of words from a source region to a destination region
// (two cycles per word: read then write) or fills a destination region with a
// constant (one cycle per word). All generated addresses wrap modulo MEM_DEPTH.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   start               one-cycle request, only honoured when idle
//   fill_mode           0 = copy src->dst, 1 = fill dst with pattern
//   src_addr, dst_addr  start word addresses
//   length              word count, clamped to MEM_DEPTH
//   pattern             fill value
//   mem_RD              asynchronous read data from the memory
//   mem_WE/mem_A/mem_WD write enable, address, write data to the memory
//   busy                high from the cycle after start until the done cycle
//   done                one-cycle completion pulse
//   words_done          words written by the current or last operation
module mem_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  fill_mode,
  input  logic [DATA_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] dst_addr,
  input  logic [DATA_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] mem_RD,
  output logic                  mem_WE,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_done
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_src;
  logic [AW-1:0]         r_dst;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_words_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_pattern;
  logic                  r_fill;

  logic [CNT_WIDTH-1:0]  w_len_clamped;
  logic [AW-1:0]         w_src_start;
  logic [AW-1:0]         w_dst_start;
  logic [AW-1:0]         w_src_inc;
  logic [AW-1:0]         w_dst_inc;

  assign w_len_clamped = (length > DATA_WIDTH'(MEM_DEPTH)) ? CNT_WIDTH'(MEM_DEPTH)
                                                           : length[CNT_WIDTH-1:0];
  assign w_src_start   = AW'(src_addr % DATA_WIDTH'(MEM_DEPTH));
  assign w_dst_start   = AW'(dst_addr % DATA_WIDTH'(MEM_DEPTH));
  // Explicit wrap so non-power-of-two depths also stay inside the memory.
  assign w_src_inc     = (r_src == AW'(MEM_DEPTH - 1)) ? '0 : r_src + 1'b1;
  assign w_dst_inc     = (r_dst == AW'(MEM_DEPTH - 1)) ? '0 : r_dst + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory controls are decoded from the state register only, so an
  // asynchronous reset forces mem_WE low immediately without a clock edge.
  always_comb begin
    w_next = r_state;
    mem_WE = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_clamped == '0) begin
            w_next = S_DONE;
          end else begin
            w_next = fill_mode ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        mem_A  = DATA_WIDTH'(r_src);
        w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_A  = DATA_WIDTH'(r_dst);
        mem_WD = r_fill ? r_pattern : r_data;
        mem_WE = 1'b1;
        if (r_count == CNT_WIDTH'(1)) begin
          w_next = S_DONE;
        end else begin
          w_next = r_fill ? S_WRITE : S_READ;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_count      <= '0;
      r_words_done <= '0;
      r_data       <= '0;
      r_pattern    <= '0;
      r_fill       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are captured only here, so a start while busy cannot disturb them.
          if (start) begin
            r_src        <= w_src_start;
            r_dst        <= w_dst_start;
            r_count      <= w_len_clamped;
            r_pattern    <= pattern;
            r_fill       <= fill_mode;
            r_words_done <= '0;
          end
        end
        S_READ: begin
          r_data <= mem_RD;
        end
        S_WRITE: begin
          r_src        <= w_src_inc;
          r_dst        <= w_dst_inc;
          r_count      <= r_count - 1'b1;
          r_words_done <= r_words_done + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign words_done = r_words_done;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine with a word-level memory model
module tb_mem_copy_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        fill_mode = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [31:0] length = '0;
  logic [31:0] pattern = '0;
  logic [31:0] mem_RD;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        busy;
  logic        done;
  logic [8:0]  words_done;

  mem_copy_engine #(.DATA_WIDTH(32), .MEM_DEPTH(256), .CNT_WIDTH(9)) dut (
    .CLK(CLK), .RST(RST), .start(start), .fill_mode(fill_mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
    .mem_RD(mem_RD), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .busy(busy), .done(done), .words_done(words_done)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [256];
  logic [31:0] model [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_a = '0;
  logic [31:0] tb_d = '0;

  assign mem_RD = mem[mem_A[7:0]];
  always @(posedge CLK) begin
    if (mem_WE) mem[mem_A[7:0]] <= mem_WD;
    else if (tb_we) mem[tb_a] <= tb_d;
  end

  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { int words; int cycles; } done_t;
  wr_t   wq[$];
  done_t dq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    wr_t   e;
    done_t d;
    if (!RST) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_WE) begin
        if (wq.size() == 0) check("unexpected_write", 64'(mem_A), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = wq.pop_front();
          check("wr_addr", 64'(mem_A), 64'(e.a));
          check("wr_data", 64'(mem_WD), 64'(e.d));
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 64'(done), 64'(0));
        else begin
          d = dq.pop_front();
          check("words_done", 64'(words_done), 64'(d.words));
          check("busy_cycles", 64'(busy_cnt), 64'(d.cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    tb_we = 1'b1; tb_a = 8'(a); tb_d = d;
    model[a] = d;
    @(posedge CLK); #1;
    tb_we = 1'b0;
  endtask

  // Reference: word i reads model[src+i] after words 0..i-1 were written.
  task automatic issue(input bit fill, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] len, input logic [31:0] pat, input int limit);
    int n;
    int k;
    logic [7:0]  sa;
    logic [7:0]  da;
    logic [31:0] v;
    n = (len > 32'd256) ? 256 : int'(len);
    k = (limit >= 0 && limit < n) ? limit : n;
    for (int i = 0; i < k; i++) begin
      sa = 8'(src + 32'(i));
      da = 8'(dst + 32'(i));
      v  = fill ? pat : model[sa];
      model[da] = v;
      wq.push_back('{a: da, d: v});
    end
    if (limit < 0) dq.push_back('{words: n, cycles: (n == 0) ? 1 : (fill ? n + 1 : 2 * n + 1)});
    fill_mode = fill; src_addr = src; dst_addr = dst; length = len; pattern = pat;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    if (!seen) check({name, "_timeout"}, 64'(0), 64'(1));
    @(posedge CLK); #1;
  endtask

  task automatic post_check(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) nbad++;
    check({name, "_mem_mismatches"}, 64'(nbad), 64'(0));
    check({name, "_queues_drained"}, 64'(wq.size() + dq.size()), 64'(0));
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic run(input string name, input bit fill, input logic [31:0] src,
                     input logic [31:0] dst, input logic [31:0] len, input logic [31:0] pat);
    issue(fill, src, dst, len, pat, -1);
    wait_done(name);
    post_check(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #12;
    check("rst_we", 64'(mem_WE), 64'(0));
    check("rst_a", 64'(mem_A), 64'(0));
    check("rst_wd", 64'(mem_WD), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_words", 64'(words_done), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, $urandom);

    poke(10, 32'hA1); poke(11, 32'hB2); poke(12, 32'hC3); poke(13, 32'hD4);
    run("copy4", 1'b0, 32'd10, 32'd100, 32'd4, 32'h0);
    check("copy4_word3", 64'(mem[103]), 64'hD4);

    run("fill_wrap", 1'b1, 32'd0, 32'd250, 32'd10, 32'hDEADBEEF);
    check("fill_wrap_word0", 64'(mem[0]), 64'hDEADBEEF);

    run("len0", 1'b0, 32'd7, 32'd8, 32'd0, 32'h0);
    run("fill_clamp", 1'b1, 32'd0, 32'd17, 32'd1000, 32'h5A5A_0F0F);

    poke(20, 32'h11); poke(21, 32'h22);
    run("overlap", 1'b0, 32'd20, 32'd21, 32'd2, 32'h0);
    check("overlap_21", 64'(mem[21]), 64'h11);
    check("overlap_22", 64'(mem[22]), 64'h11);
    run("same", 1'b0, 32'd20, 32'd20, 32'd2, 32'h0);

    issue(1'b0, 32'd30, 32'd130, 32'd3, 32'h0, -1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        start = 1'b1; fill_mode = 1'($urandom); src_addr = $urandom; dst_addr = $urandom;
        length = $urandom_range(1, 300); pattern = $urandom;
        @(posedge CLK); #1;
      end
    end
    start = 1'b0;
    check("ignore_start_done_seen", 64'(seen), 64'(1));
    repeat (3) @(posedge CLK);
    #1;
    post_check("ignore_start");

    issue(1'b1, 32'd0, 32'd60, 32'd5, 32'hCAFE_F00D, 2);
    @(posedge CLK);
    @(posedge CLK); #1;
    check("mid_write_we", 64'(mem_WE), 64'(1));
    RST = 1'b0;
    #1;
    check("async_we_drop", 64'(mem_WE), 64'(0));
    check("async_outputs_zero", 64'({busy, done, words_done, mem_A, mem_WD}), 64'(0));
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    post_check("reset_abort");
    run("after_reset", 1'b0, 32'd60, 32'd200, 32'd6, 32'h0);

    for (int t = 0; t < 10; t++) begin
      logic [31:0] len;
      len = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run("random", 1'($urandom), $urandom, $urandom, len, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
